ml_matvec_sched: RTL
====================

Name: ml_matvec_sched

Overview:
- Controller that sequences one shared signed multiply-accumulate datapath to compute y = A·x.
- A is ROWS×COLS, row-major, held in an external synchronous RAM. x is held in a second RAM. Both RAMs have 1-cycle read latency.
- Emits one result per row over a valid/ready stream. Start/busy/done handshake toward the host.
- Hardware counterpart of the MathLib matrix-vector routines, used by MathLib-based testbenches as the DUT reference engine.

Parameters:
- ROWS, 4, number of matrix rows (≥1)
- COLS, 4, number of matrix columns / vector length (≥1)
- DW, 16, signed element width of A and x
- ACCW, 2*DW+$clog2(COLS)+1, signed accumulator / result width

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  begin operation; sampled only in IDLE
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse after the last row's handshake
- a_rd_o  out  1  read strobe, matrix RAM
- a_addr_o  out  $clog2(ROWS*COLS)  address row*COLS+col
- a_data_i  in  DW  signed; valid the cycle after a_rd_o
- x_addr_o  out  $clog2(COLS)  address col; strobe shared with a_rd_o
- x_data_i  in  DW  signed; valid the cycle after a_rd_o
- y_valid_o  out  1  result valid
- y_ready_i  in  1  downstream accept
- y_row_o  out  $clog2(ROWS)  row index of y_data_o
- y_data_o  out  ACCW  signed row dot product

Behaviour:
- Reset:
  - FSM goes to IDLE; row and col counters go to 0; accumulator goes to 0.
  - All outputs are 0, including addresses.
  - Reset mid-operation aborts immediately. No done_o pulse. Pending result is discarded.
- FSM states: IDLE, ISSUE, DRAIN, OUT.
  - IDLE: start_i=1 → ISSUE with row=0, col=0.
  - ISSUE: a_rd_o=1, addresses from (row, col); col increments each cycle. At col==COLS-1 → DRAIN.
  - DRAIN: one cycle; the last product is accumulated.
  - OUT: y_valid_o=1; y_data_o and y_row_o held stable.
  - OUT with y_ready_i=1: if row==ROWS-1 → IDLE and pulse done_o (done_o high in the first IDLE cycle); else row++, col=0 → ISSUE.
- start_i is ignored outside IDLE.
- y_valid_o never drops without a handshake. y_data_o/y_row_o do not change while y_valid_o=1.
- Datapath (sub-module ml_mac_unit):
  - rd_q = a_rd_o delayed one cycle; first_q = (col==0) delayed one cycle.
  - When rd_q=1: acc ← (first_q ? 0 : acc) + sext(a_data_i*x_data_i).
  - Product width is 2*DW, signed, sign-extended to ACCW.
  - Accumulation wraps two's complement in ACCW; no saturation. The default ACCW cannot overflow.
- y_data_o = acc while in OUT.
- Latency with y_ready_i tied high, start accepted at cycle 0:
  - ISSUE in cycles 1..COLS, DRAIN at COLS+1, OUT at COLS+2.
  - Row period is COLS+2.
  - done_o at cycle 1+ROWS*(COLS+2); busy_o low in that same cycle.
- Backpressure: every cycle y_ready_i=0 in OUT adds one cycle; no RAM reads occur during stall.
- ROWS=1 and COLS=1 must work. COLS=1 means ISSUE lasts one cycle; address widths use max(1, clog2).

Decomposition:
- Shared package MathLib_hw_pkg holds:
  - typedef enum ml_sched_state_e {IDLE, ISSUE, DRAIN, OUT}
  - function ml_accw(dw, cols)
  - localparam ML_RAM_RD_LAT=1
- One sub-module, ml_mac_unit (params DW, ACCW; ports clk, rst, en, clr_first, a, b, acc). It is reusable by later MathLib engines.
- ml_matvec_sched holds only the FSM, counters and address generation.

Test Plan:
- Identity: A=I4, x={1,2,3,4}, ready high → y rows 0..3 = 1,2,3,4; first y_valid_o at cycle 6; done_o at cycle 25.
- Signed values: A row0={-1,2,-3,4}, x={5,-6,7,-8} → y[0] = -5-12-21-32 = -70. Extremes: all A=-32768, x=-32768 → y = 4·2^30 = 4294967296 with no overflow at ACCW=35.
- Backpressure: y_ready_i low 3 cycles at row 1 → y_valid_o and data held for 4 cycles; no a_rd_o during stall; done_o delayed by exactly 3 cycles.
- Start while busy: start_i pulsed at cycles 3 and 12 → ignored; a single done_o; a 2nd start right after done_o restarts at row 0.
- Reset mid-op: rst at cycle 10 → next cycle all outputs 0 and busy_o=0, no done_o; a new start produces correct results.
- Degenerate: ROWS=1, COLS=1, A={7}, x={-3} → y=-21 at cycle 3, done_o at cycle 4.

Source files
------------

// File: rtl/MathLib_hw_pkg.sv
// MathLib_hw_pkg: shared types, constants and width helpers for MathLib hardware engines
package MathLib_hw_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} ml_sched_state_e;
  localparam int ML_RAM_RD_LAT = 1;
  function automatic int ml_accw(input int dw, input int cols);
    return 2 * dw + $clog2(cols) + 1;
  endfunction
endpackage

// File: rtl/ml_mac_unit.sv
// ml_mac_unit: signed multiply-accumulate aligned to the RAM read latency
module ml_mac_unit import MathLib_hw_pkg::*; #(
  parameter int DW = 16,
  parameter int ACCW = 35
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr_first,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);
  logic [ML_RAM_RD_LAT-1:0] rd_sr, first_sr;
  logic signed [2*DW-1:0] prod;
  assign prod = a * b;
  // delay the read strobe and first-column flag until the RAM data arrives
  always_ff @(posedge clk)
    if (rst) begin
      rd_sr <= '0;
      first_sr <= '0;
    end else begin
      rd_sr <= (rd_sr << 1) | ML_RAM_RD_LAT'(en);
      first_sr <= (first_sr << 1) | ML_RAM_RD_LAT'(clr_first);
    end
  // restart the sum on the first column, otherwise keep adding sign-extended products
  always_ff @(posedge clk)
    if (rst) acc <= '0;
    else if (rd_sr[ML_RAM_RD_LAT-1]) acc <= (first_sr[ML_RAM_RD_LAT-1] ? '0 : acc) + ACCW'(prod);
endmodule

// File: rtl/ml_matvec_sched.sv
// ml_matvec_sched: sequences one shared MAC over a row-major matrix RAM to stream y = A*x
module ml_matvec_sched import MathLib_hw_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW = 16,
  parameter int ACCW = ml_accw(DW, COLS),
  localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   a_rd_o,
  output logic [AW-1:0]          a_addr_o,
  input  logic signed [DW-1:0]   a_data_i,
  output logic [CW-1:0]          x_addr_o,
  input  logic signed [DW-1:0]   x_data_i,
  output logic                   y_valid_o,
  input  logic                   y_ready_i,
  output logic [RW-1:0]          y_row_o,
  output logic signed [ACCW-1:0] y_data_o
);
  ml_sched_state_e state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic signed [ACCW-1:0] acc;
  logic last_col, last_row, hs;
  assign last_col = col == CW'(COLS - 1);
  assign last_row = row == RW'(ROWS - 1);
  assign hs = state == OUT && y_ready_i;
  // sequencing FSM with row/column counters; done fires after the final row handshake
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= hs && last_row;
      case (state)
        IDLE: if (start_i) begin
          state <= ISSUE;
          row <= '0;
          col <= '0;
        end
        ISSUE: begin
          col <= last_col ? '0 : col + 1'b1;
          if (last_col) state <= DRAIN;
        end
        DRAIN: state <= OUT;
        OUT: if (y_ready_i) begin
          state <= last_row ? IDLE : ISSUE;
          row <= last_row ? '0 : row + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  // addresses and results are forced to zero when not in use
  always_comb begin
    busy_o = state != IDLE;
    a_rd_o = state == ISSUE;
    a_addr_o = a_rd_o ? AW'(32'(row) * COLS + 32'(col)) : '0;
    x_addr_o = a_rd_o ? col : '0;
    y_valid_o = state == OUT;
    y_row_o = y_valid_o ? row : '0;
    y_data_o = y_valid_o ? acc : '0;
  end
  ml_mac_unit #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk(clk),
    .rst(rst),
    .en(a_rd_o),
    .clr_first(col == '0),
    .a(a_data_i),
    .b(x_data_i),
    .acc(acc)
  );
endmodule
